hilo_muldiv_unit: RTL and testbench

Iterative multiply/divide unit that owns the architectural HI/LO registers, replacing the single-cycle combinational HI/LO block in the execute stage.
- Parametrised in datapath width.
- Supports signed and unsigned multiply and divide, plus mthi/mtlo, over a multi-cycle radix-2 datapath.
- Exports `busy` so the hazard unit can stall mfhi/mflo, and any new muldiv, until the result is ready.
- Sits beside the ALU in the execute stage.

---
 rtl/hilo_muldiv_unit_pkg.sv | 23 ++
 rtl/hilo_muldiv_unit_if.sv | 31 +++
 rtl/hilo_muldiv_unit_step.sv | 31 +++
 rtl/hilo_muldiv_unit.sv | 132 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit and the execute stage.
package hilo_muldiv_unit_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage port bundle of the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  // start is taken only in a cycle with busy=0 and cancel=0; while busy=1 the
  // unit ignores start, and done pulses once when HI/LO first hold the result.
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             mf_sel;
  logic [WIDTH-1:0] mf_out;
  logic             busy;
  logic             done;
  md_state_e        dbg_state;

  modport master (
    output start, op, src_a, src_b, cancel, mf_sel,
    input  mf_out, busy, done, dbg_state
  );

  modport slave (
    input  start, op, src_a, src_b, cancel, mf_sel,
    output mf_out, busy, done, dbg_state
  );

endinterface

// File: rtl/hilo_muldiv_unit_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_mul_sum;
  logic [WIDTH:0] w_div_rem;
  logic [WIDTH:0] w_div_diff;

  // Multiply keeps the multiplier in the low half and retires one bit per step;
  // divide shifts dividend bits into the remainder and quotient bits in at bit 0.
  always_comb begin
    w_mul_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_div_rem  = i_acc[2*WIDTH-1:WIDTH-1];
    w_div_diff = w_div_rem - {1'b0, i_opnd};
    o_acc      = {w_mul_sum, i_acc[WIDTH-1:1]};
    if (i_div) begin
      if (!w_div_diff[WIDTH]) begin
        o_acc = {w_div_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {w_div_rem[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  hilo_muldiv_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_done, r_is_div, r_neg_q, r_neg_r, r_dbz;

  logic               w_accept, w_signed, w_div, w_sa, w_sb, w_dbz;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_acc_step, w_prod;

  // Ops 0-3 have op[2]=0; op[1] selects divide, op[0]=0 selects the signed form.
  assign w_accept = bus.start && !bus.cancel && (r_state == ST_IDLE);
  assign w_signed = !bus.op[0];
  assign w_div    = bus.op[1];
  assign w_sa     = w_signed && bus.src_a[WIDTH-1];
  assign w_sb     = w_signed && bus.src_b[WIDTH-1];
  assign w_mag_a  = w_sa ? -bus.src_a : bus.src_a;
  assign w_mag_b  = w_sb ? -bus.src_b : bus.src_b;
  assign w_dbz    = w_div && (bus.src_b == '0);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_is_div),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_step)
  );

  // On divide-by-zero the low half still holds |dividend|; restoring its sign
  // hands the original dividend back as HI.
  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_quo    = r_acc[WIDTH-1:0];
    w_rem    = r_acc[2*WIDTH-1:WIDTH];
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_dbz) begin
        w_res_lo = '1;
        w_res_hi = r_neg_r ? -w_quo : w_quo;
      end else begin
        w_res_lo = r_neg_q ? -w_quo : w_quo;
        w_res_hi = r_neg_r ? -w_rem : w_rem;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !bus.op[2]) w_state_nxt = w_dbz ? ST_FIX : ST_CALC;
      ST_CALC: begin
        if (bus.cancel) w_state_nxt = ST_IDLE;
        else if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !bus.op[2]) begin
            r_is_div <= w_div;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_dbz    <= w_dbz;
            r_cnt    <= '0;
            r_opnd   <= w_div ? w_mag_b : w_mag_a;
            r_acc    <= {{WIDTH{1'b0}}, (w_div ? w_mag_a : w_mag_b)};
          end else if (w_accept && (bus.op == MD_MTHI)) begin
            r_hi <= bus.src_a;
          end else if (w_accept && (bus.op == MD_MTLO)) begin
            r_lo <= bus.src_a;
          end
        end
        ST_CALC: begin
          if (!bus.cancel) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_FIX: begin
          if (!bus.cancel) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mf_out    = bus.mf_sel ? r_lo : r_hi;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomised and directed bench for hilo_muldiv_unit against an arithmetic model.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int W = MD_WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus ();
  hilo_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0]   m_hi, m_lo;
  logic [2*W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic ('/' truncates toward zero,
  // '%' follows the dividend's sign).
  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [2*W-1:0] ua, ub, p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    p  = '0;
    case (md_op_e'(op))
      MD_MULT:  p = 64'(sa * sb);
      MD_MULTU: p = ua * ub;
      MD_DIV: begin
        if (b == '0) p = {a, {W{1'b1}}};
        else begin
          q = sa / sb; r = sa % sb;
          qv = 64'(q); rv = 64'(r);
          p = {rv[W-1:0], qv[W-1:0]};
        end
      end
      MD_DIVU: begin
        if (b == '0) p = {a, {W{1'b1}}};
        else begin
          qv = ua / ub; rv = ua % ub;
          p = {rv[W-1:0], qv[W-1:0]};
        end
      end
      default: p = {m_hi, m_lo};
    endcase
    return p;
  endfunction

  task automatic check_hilo(input string tag);
    logic [W-1:0] hi, lo;
    bus.mf_sel = 1'b0; #1; hi = bus.mf_out;
    bus.mf_sel = 1'b1; #1; lo = bus.mf_out;
    check_eq({tag, "_hi"}, hi, m_hi);
    check_eq({tag, "_lo"}, lo, m_lo);
  endtask

  task automatic do_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    int cnt, exp_busy;
    exp_q.push_back(model(op, a, b));
    exp_busy = (op[1] && b == '0) ? 1 : W + 1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'd6;
    cnt = 0;
    for (int k = 0; k < 3 * W && !bus.done; k++) begin
      if (bus.busy) cnt++;
      if (cnt == 3) begin
        bus.mf_sel = 1'b0; #1;
        check_eq("no_bypass_hi", bus.mf_out, m_hi);
      end
      if (inject && cnt == 5) begin
        bus.start = 1'b1; bus.op = 3'($urandom_range(0, 5));
        bus.src_a = $urandom; bus.src_b = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check_eq("done_pulse", bus.done, 1);
    check_eq("busy_cycles", cnt, exp_busy);
    check_eq("busy_at_done", bus.busy, 0);
    {m_hi, m_lo} = exp_q.pop_front();
    check_hilo("md_result");
    @(posedge clk); #1;
    check_eq("done_one_cycle", bus.done, 0);
  endtask

  task automatic do_simple(input logic [2:0] op, input logic [W-1:0] a, input bit with_cancel);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.cancel = with_cancel;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    if (!with_cancel && op == MD_MTHI) m_hi = a;
    if (!with_cancel && op == MD_MTLO) m_lo = a;
    check_eq("simple_busy", bus.busy, 0);
    check_eq("simple_done", bus.done, 0);
    check_hilo("simple");
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return W'(1);
      4: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 3'd6; bus.src_a = '0; bus.src_b = '0;
    bus.cancel = 1'b0; bus.mf_sel = 1'b0;
    m_hi = '0; m_lo = '0;
    #12;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_state", bus.dbg_state, ST_IDLE);
    check_hilo("rst");
    @(negedge clk); reset = 1'b0;

    do_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("multu_max_hi", m_hi, 32'hFFFF_FFFE);
    do_md(MD_MULT, -32'sd3, 32'd5, 1'b0);
    do_md(MD_DIV, -32'sd7, 32'd2, 1'b0);
    check_eq("div_neg_lo", m_lo, 32'hFFFF_FFFD);
    do_md(MD_DIVU, 32'd100, 32'd0, 1'b0);
    do_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // MTHI and MTLO on back-to-back cycles
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MTHI; bus.src_a = 32'h1234_5678;
    @(posedge clk); #1;
    check_eq("mthi_busy", bus.busy, 0);
    bus.mf_sel = 1'b0; #1;
    check_eq("mthi_read", bus.mf_out, 32'h1234_5678);
    bus.op = MD_MTLO; bus.src_a = 32'hCAFE_BABE;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("mtlo_busy", bus.busy, 0);
    bus.mf_sel = 1'b1; #1;
    check_eq("mtlo_read", bus.mf_out, 32'hCAFE_BABE);
    m_hi = 32'h1234_5678; m_lo = 32'hCAFE_BABE;

    // Cancel mid-MULT, with an MTLO start dropped while busy
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MULT; bus.src_a = 32'd7; bus.src_b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'd6;
    for (int k = 1; k < 10; k++) begin
      bus.start = (k == 4);
      bus.op = (k == 4) ? MD_MTLO : 3'd6;
      bus.src_a = 32'hDEAD_BEEF;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check_eq("cancel_pre_busy", bus.busy, 1);
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check_eq("cancel_busy", bus.busy, 0);
    for (int k = 0; k < 4; k++) begin
      check_eq("cancel_no_done", bus.done, 0);
      @(posedge clk); #1;
    end
    check_hilo("cancel_keep");

    do_simple(MD_MTHI, 32'h5555_AAAA, 1'b1);
    do_simple(MD_NOP7, 32'h0BAD_F00D, 1'b0);

    // Asynchronous reset in the middle of a DIVU
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_done", bus.done, 0);
    m_hi = '0; m_lo = '0;
    check_hilo("arst");
    @(negedge clk); reset = 1'b0;
    do_md(MD_DIVU, 32'd10, 32'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op < 3'd4)      do_md(op, pick_val(), pick_val(), ($urandom_range(0, 3) == 0));
      else if (op < 3'd6) do_simple(op, W'($urandom), 1'b0);
      else                do_simple(op, W'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
